// File: rtl/instr_mem_responder_if.sv
// Instruction fetch bus: req/gnt request phase, rvalid/rdata/err response phase.
interface instr_mem_responder_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, addr,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/instr_mem_responder.sv
// Pipelined instruction memory responder with preload port.
// Optional gnt stalling by a 16-bit LFSR under `INSTR_RESP_STALL_EN.
module instr_mem_responder #(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          NUM_WORDS       = 1024,
  parameter int          LATENCY         = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  instr_mem_responder_if.slave         bus,
  input  logic                         load_we_i,
  input  logic [$clog2(NUM_WORDS)-1:0] load_addr_i,
  input  logic [31:0]                  load_wdata_i
);
  localparam int          AW   = $clog2(NUM_WORDS);
  localparam int          CW   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] SPAN = 32'(4 * NUM_WORDS);

  logic [31:0]        mem [NUM_WORDS];
  logic [CW-1:0]      out_cnt;
  logic [LATENCY-1:0] pv;
  logic [LATENCY-1:0] pe;
  logic [31:0]        pd [LATENCY];
  logic               stall;
  logic               accept;
  logic               retire;
  logic               in_range;
  logic [31:0]        off;
  logic [AW-1:0]      idx;

  assign off      = bus.addr - BASE_ADDR;
  assign in_range = (off < SPAN) && (bus.addr[1:0] == 2'b00);
  assign idx      = off[AW+1:2];

  assign bus.gnt = !rst_i && !stall
                && (out_cnt < CW'(MAX_OUTSTANDING));
  assign accept  = bus.req && bus.gnt;

`ifdef INSTR_RESP_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0],
               lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i && load_we_i) begin
      mem[load_addr_i] <= load_wdata_i;
    end
  end

  // Stage 0 captures the store at the accept edge; the
  // non-blocking read gives read-before-write against the load port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pv <= '0;
      pe <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pd[i] <= '0;
      end
    end else begin
      pv[0] <= accept;
      pe[0] <= accept && !in_range;
      pd[0] <= (accept && in_range) ? mem[idx] : 32'h0;
      for (int i = 1; i < LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  // A request retires on the edge that moves it into the output stage.
  generate
    if (LATENCY > 1) begin : g_retire_pipe
      assign retire = pv[LATENCY-2];
    end else begin : g_retire_now
      assign retire = accept;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_cnt <= '0;
    end else if (accept && !retire) begin
      out_cnt <= out_cnt + CW'(1);
    end else if (!accept && retire) begin
      out_cnt <= out_cnt - CW'(1);
    end
  end

  assign bus.rvalid = pv[LATENCY-1];
  assign bus.err    = pe[LATENCY-1];
  assign bus.rdata  = pd[LATENCY-1];
endmodule

// File: tb/tb_instr_mem_responder.sv
// Randomized bench for instr_mem_responder against a queue-based model.
// Two instances: MAX_OUTSTANDING 2 at base 0, MAX_OUTSTANDING 1 at base 0x1000.
module tb_instr_mem_responder;
  localparam int          LAT   = 2;
  localparam int          NW    = 1024;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_1000;
  localparam int          MAX0  = 2;
  localparam int          MAX1  = 1;

  typedef struct {
    int          k;
    int          due;
    logic        err;
    logic [31:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        lwe;
  logic [9:0]  laddr;
  logic [31:0] lwd;

  always #5 clk = ~clk;

  instr_mem_responder_if b0 ();
  instr_mem_responder_if b1 ();

  assign b0.req  = req;
  assign b0.addr = addr;
  assign b1.req  = req;
  assign b1.addr = addr;

  instr_mem_responder #(
    .BASE_ADDR(BASE0), .NUM_WORDS(NW),
    .LATENCY(LAT), .MAX_OUTSTANDING(MAX0)
  ) dut0 (
    .clk_i(clk), .rst_i(rst), .bus(b0.slave),
    .load_we_i(lwe), .load_addr_i(laddr),
    .load_wdata_i(lwd)
  );

  instr_mem_responder #(
    .BASE_ADDR(BASE1), .NUM_WORDS(NW),
    .LATENCY(LAT), .MAX_OUTSTANDING(MAX1)
  ) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(b1.slave),
    .load_we_i(lwe), .load_addr_i(laddr),
    .load_wdata_i(lwd)
  );

  logic [31:0] mem [NW];
  resp_t       q[$];
  int          n;
  logic [15:0] lfsr_m;
  int          tests;
  int          fails;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @edge %0d: got %h expected %h",
               tag, n, got, exp);
    end
  endtask

  function automatic int head(input int k);
    for (int i = 0; i < q.size(); i++)
      if (q[i].k == k) return i;
    return -1;
  endfunction

  function automatic int pend(input int k);
    int c = 0;
    foreach (q[i]) if (q[i].k == k) c++;
    return c;
  endfunction

  function automatic resp_t lookup(input int k, input logic [31:0] base,
                                   input logic [31:0] a);
    resp_t       r;
    logic [31:0] off;
    off    = a - base;
    r.k    = k;
    r.due  = n + LAT;
    r.err  = !(off < 32'(4 * NW) && a[1:0] == 2'b00);
    r.data = r.err ? 32'h0 : mem[off[11:2]];
    return r;
  endfunction

  task automatic chk_rsp(input int k, input string tag,
                         input logic rv, input logic [31:0] rd,
                         input logic er);
    int h;
    h = head(k);
    if (h >= 0 && q[h].due == n) begin
      check({tag, ".rvalid"}, 32'(rv), 32'd1);
      check({tag, ".rdata"}, rd, q[h].data);
      check({tag, ".err"}, 32'(er), 32'(q[h].err));
      q.delete(h);
    end else begin
      check({tag, ".rvalid"}, 32'(rv), 32'd0);
      check({tag, ".rdata"}, rd, 32'h0);
      check({tag, ".err"}, 32'(er), 32'd0);
    end
  endtask

  // One clock: check outputs before edge n, then advance the model.
  task automatic step();
    logic  stall;
    logic  g0;
    logic  g1;
    resp_t r0;
    resp_t r1;
    @(negedge clk);
    stall = 1'b0;
`ifdef INSTR_RESP_STALL_EN
    stall = lfsr_m[0];
`endif
    chk_rsp(0, "d0", b0.rvalid, b0.rdata, b0.err);
    chk_rsp(1, "d1", b1.rvalid, b1.rdata, b1.err);
    g0 = !rst && !stall && pend(0) < MAX0;
    g1 = !rst && !stall && pend(1) < MAX1;
    check("d0.gnt", 32'(b0.gnt), 32'(g0));
    check("d1.gnt", 32'(b1.gnt), 32'(g1));
    r0 = lookup(0, BASE0, addr);
    r1 = lookup(1, BASE1, addr);
    @(posedge clk);
    if (rst) begin
      q.delete();
      lfsr_m = 16'hACE1;
    end else begin
      if (req && g0) q.push_back(r0);
      if (req && g1) q.push_back(r1);
      if (lwe) mem[laddr] = lwd;
      lfsr_m = {lfsr_m[14:0],
                lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end
    n++;
    #1;
  endtask

  task automatic idle(input int c);
    req = 1'b0;
    lwe = 1'b0;
    repeat (c) step();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    req   = 1'b0;
    addr  = '0;
    lwe   = 1'b0;
    laddr = '0;
    lwd   = '0;
    repeat (2) @(posedge clk);
    #1;
    n      = 0;
    lfsr_m = 16'hACE1;
    repeat (2) step();
    rst = 1'b0;

    // Preload every word; words 0..3 fixed, word 5 zero.
    for (int i = 0; i < NW; i++) begin
      lwe   = 1'b1;
      laddr = 10'(i);
      lwd   = (i < 4) ? 32'h1111_1111 * (i + 1)
            : (i == 5) ? 32'h0 : $urandom;
      step();
    end
    idle(3);

    req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = 32'(4 * i);
      step();
    end
    idle(6);

    req = 1'b1;
    addr = 32'h0000_1000;
    step();
    addr = 32'h0000_0006;
    step();
    idle(6);

    req   = 1'b1;
    addr  = 32'h14;
    lwe   = 1'b1;
    laddr = 10'd5;
    lwd   = 32'hDEAD_BEEF;
    step();
    lwe = 1'b0;
    idle(4);
    req = 1'b1;
    repeat (3) step();
    idle(4);

    req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      addr = 32'(4 * $urandom_range(0, NW - 1));
      step();
    end

    req  = 1'b1;
    addr = 32'h20;
    repeat (2) step();
    req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(5);

    for (int i = 0; i < 3000; i++) begin
      int s;
      req = ($urandom_range(0, 3) != 0);
      s   = $urandom_range(0, 9);
      if (s == 0)
        addr = $urandom;
      else if (s == 1)
        addr = 32'(4 * $urandom_range(0, NW - 1)) + 32'($urandom_range(1, 3));
      else
        addr = ($urandom_range(0, 1) ? BASE1 : BASE0)
             + 32'(4 * $urandom_range(0, NW - 1));
      lwe   = ($urandom_range(0, 3) == 0);
      laddr = 10'($urandom_range(0, NW - 1));
      lwd   = $urandom;
      rst   = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    idle(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
